// File: rtl/countdown_timer.sv
// Loadable 8-bit down counter with run/done control and terminal-count pulse.
// Two active-low 7-segment digits show the current count in hex.
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       start,
  input  logic       en,
  output logic [7:0] Q,
  output logic       tc,
  output logic       busy,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [7:0] reload;
  logic [7:0] q_nx;
  logic [7:0] reload_nx;
  logic       tc_nx;
  logic       last;

  // One count left: the next enabled cycle is the terminal event.
  assign last = (Q <= 8'd1);

  // Active-low hex digit pattern, bit0 = segment a ... bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // State register; busy is registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
    end
  end

  // Next-state logic; load wins over everything and parks in IDLE.
  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: if (start && (Q != 8'd0)) state_nx = RUN;
        RUN:  if (en && last && !AUTO_RELOAD) state_nx = DONE;
        DONE: state_nx = DONE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Output/datapath next values: count, reload value and tc pulse.
  always_comb begin
    q_nx      = Q;
    reload_nx = reload;
    tc_nx     = 1'b0;
    if (load) begin
      q_nx      = din;
      reload_nx = din;
    end else if ((state == RUN) && en) begin
      if (!last) begin
        q_nx = Q - 8'd1;
      end else begin
        tc_nx = 1'b1;
        q_nx  = AUTO_RELOAD ? reload : 8'd0;
      end
    end
  end

  // Datapath registers; reset clears the count and the reload value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Q      <= 8'd0;
      reload <= 8'd0;
      tc     <= 1'b0;
    end else begin
      Q      <= q_nx;
      reload <= reload_nx;
      tc     <= tc_nx;
    end
  end

  assign HEX0 = seg7(Q[3:0]);
  assign HEX1 = seg7(Q[7:4]);

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter AUTO_RELOAD, default 0: 0 = stop at zero; 1 = reload the last loaded value and keep running.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port load  input  1  when high, captures din into the count and the reload register.
REQ-005 SHALL have port din  input  8  start value.
REQ-006 SHALL have port start  input  1  one-cycle request to begin counting down.
REQ-007 SHALL have port en  input  1  count enable; decrement occurs only while RUN and en=1.
REQ-008 SHALL have port Q  output  8  current count.
REQ-009 SHALL have port tc  output  1  registered terminal-count pulse.
REQ-010 SHALL have port busy  output  1  high while in RUN.
REQ-011 SHALL have port HEX0  output  7  active-low 7-segment pattern of Q[3:0]; bit0=a ... bit6=g.
REQ-012 SHALL have port HEX1  output  7  active-low 7-segment pattern of Q[7:4]; same coding as HEX0.

Function
REQ-013 SHALL implement FSM states IDLE, RUN and DONE.
REQ-014 SHALL give load priority over start and en in every state: Q<=din, reload<=din, next state IDLE, tc=0.
REQ-015 SHALL, in IDLE, move to RUN on start=1 with Q!=0; start with Q==0 is ignored (stay IDLE, tc=0).
REQ-016 SHALL, in RUN with en=0, hold Q and state.
REQ-017 SHALL, in RUN with en=1 and Q>1, set Q<=Q-1.
REQ-018 SHALL, in RUN with en=1 and Q==1 and AUTO_RELOAD=0, set Q<=0, assert tc for that one cycle, and go to DONE.
REQ-019 SHALL, in RUN with en=1 and Q==1 and AUTO_RELOAD=1, set Q<=reload, assert tc for that one cycle, and stay in RUN, giving a tc period of reload enabled cycles.
REQ-020 SHALL, in DONE, hold Q=0; start without load is ignored; load returns to IDLE per REQ-014.
REQ-021 SHALL, on load during RUN, abort the countdown per REQ-014, with no tc.
REQ-022 SHALL keep tc high for exactly one clock per terminal event and never for two consecutive cycles with AUTO_RELOAD=0.
REQ-023 SHALL drive busy=1 only in RUN, as a registered state decode.
REQ-024 SHALL decode HEX0/HEX1 combinationally from Q, with zero latency, for hex digits 0-F: 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110.
REQ-025 SHALL perform all arithmetic on 8 bits unsigned; Q never underflows past 0.

Reset
REQ-026 SHALL, while reset=1, immediately and independent of clk force: state=IDLE, Q=0x00, reload=0x00, tc=0, busy=0, HEX0=HEX1=1000000.
REQ-027 SHALL, when reset is asserted mid-RUN, discard the countdown with no tc pulse; after release, stay in IDLE until load/start.

Verification
REQ-028 SHALL cover: Q=0x37 in RUN, reset asserted between edges -> Q=0x00, busy=0 and HEX0=HEX1=1000000 before the next edge.
REQ-029 SHALL cover: load din=0x03, then start, en=1 held -> Q=3,2,1,0 on successive edges; tc=1 only in the cycle Q=0; DONE; busy=0.
REQ-030 SHALL cover: load 0x05, start, en pattern 1,0,0,1 -> Q=4,4,4,3; HEX0=0011001 at Q=4.
REQ-031 SHALL cover: load 0x20, start, count to 0x1E, then load din=0xAF -> Q=0xAF, IDLE, tc never high; HEX1=0001000, HEX0=0001110.
REQ-032 SHALL cover: AUTO_RELOAD=1, load 0x02, start, en=1 -> Q=2,1,2,1,2...; tc high each time Q returns to 2; busy stays 1.
REQ-033 SHALL cover: start with Q=0 -> no state change; load 0x09 and start in the same cycle -> Q=0x09, IDLE, busy=0.
